// File: rtl/clk_div_sched_if.sv
// Requester-side handshake bundle for clk_div_sched: request levels, requested
// counts, per-requester ack pulses, busy flag and the granted requester index.
interface clk_div_sched_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] cnt_req;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic [2:0]            grant_id;

    // Requester side
    modport master (
        output req,
        output cnt_req,
        input  ack,
        input  busy,
        input  grant_id
    );

    // Scheduler side
    modport slave (
        input  req,
        input  cnt_req,
        output ack,
        output busy,
        output grant_id
    );
endinterface

// File: rtl/clk_div_sched.sv
// Divide-ratio scheduler: round-robin arbitrates requests for a new half-period
// count, applies the granted count right after a divider toggle (or after a
// timeout when the divider is stalled), waits for it to settle, then acks.
module clk_div_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic [15:0] RESET_COUNT  = 16'd1,
    parameter int unsigned SETTLE_EDGES = 2,
    parameter int unsigned TIMEOUT_CYC  = 70000
) (
    input  logic                  clk_i,
    input  logic                  iRsn,
    clk_div_sched_if.slave        req_if,
    output logic [15:0]           count_o,
    input  logic                  div_clk_i,
    output logic                  timeout_o
);
    localparam int unsigned IdW    = 3;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]        SettleLast = 4'(SETTLE_EDGES);

    typedef enum logic [1:0] {
        StIdle,
        StWaitEdge,
        StSettle,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]      grant_q, grant_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [3:0]          edge_cnt_q, edge_cnt_d;
    logic [15:0]         cnt_sel_q, cnt_sel_d;
    logic [15:0]         count_q, count_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                timeout_q, timeout_d;
    logic                div_q;

    logic                div_edge;
    logic [7:0]          req_pad;
    logic [15:0]         cnt_arr [8];
    logic                arb_found;
    logic [IdW-1:0]      arb_idx;
    logic [IdW-1:0]      cand;
    logic [15:0]         sel_cnt;

    // Pad requests/counts to 8 slots so a 3-bit index always selects in range
    for (genvar k = 0; k < 8; k++) begin : g_pad
        if (k < NUM_REQ) begin : g_used
            assign req_pad[k] = req_if.req[k];
            assign cnt_arr[k] = req_if.cnt_req[16*k +: 16];
        end else begin : g_unused
            assign req_pad[k] = 1'b0;
            assign cnt_arr[k] = 16'd0;
        end
    end

    assign div_edge = div_clk_i ^ div_q;

    // Round-robin search: first set request at or above rr_ptr, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = IdW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!arb_found && req_pad[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
        // A zero count cannot be applied right after a toggle, so clamp to 1
        sel_cnt = (cnt_arr[arb_idx] == 16'd0) ? 16'd1 : cnt_arr[arb_idx];
    end

    // Next-state and datapath updates for the grant/apply/settle/ack sequence
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        cnt_sel_d  = cnt_sel_q;
        count_d    = count_q;
        ack_d      = '0;
        timeout_d  = 1'b0;
        busy_d     = busy_q;
        // busy drops the cycle after the ack pulse unless a new grant lands
        if (ack_q != '0) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (arb_found) begin
                    grant_d   = arb_idx;
                    cnt_sel_d = sel_cnt;
                    busy_d    = 1'b1;
                    state_d   = (sel_cnt == count_q) ? StAck : StWaitEdge;
                end
            end
            StWaitEdge: begin
                if (div_edge) begin
                    count_d    = cnt_sel_q;
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    state_d    = StSettle;
                end else if (timer_q == TimerLast) begin
                    count_d   = cnt_sel_q;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StAck;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSettle: begin
                if (div_edge) begin
                    timer_d    = '0;
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q + 4'd1 == SettleLast) begin
                        state_d = StAck;
                    end
                end else if (timer_q == TimerLast) begin
                    timer_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StAck;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StAck: begin
                ack_d    = NUM_REQ'(1) << grant_q;
                rr_ptr_d = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 3'd1;
                timer_d  = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge iRsn) begin
        if (!iRsn) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            edge_cnt_q <= '0;
            cnt_sel_q  <= RESET_COUNT;
            count_q    <= RESET_COUNT;
            busy_q     <= 1'b0;
            ack_q      <= '0;
            timeout_q  <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            edge_cnt_q <= edge_cnt_d;
            cnt_sel_q  <= cnt_sel_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
            div_q      <= div_clk_i;
        end
    end

    assign req_if.ack      = ack_q;
    assign req_if.busy     = busy_q;
    assign req_if.grant_id = grant_q;
    assign count_o         = count_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: models the external divider, predicts grant order
// and applied counts into a scoreboard, and checks acks, apply timing,
// divider half-periods, timeout and reset behaviour.
module tb_clk_div_sched;
    localparam int TimeoutCyc = 70000;

    logic        clk;
    logic        rst_n;
    logic [15:0] count;
    logic        div_clk;
    logic        tmo;

    clk_div_sched_if #(.NUM_REQ(4)) bus ();

    clk_div_sched #(
        .NUM_REQ     (4),
        .RESET_COUNT (16'd1),
        .SETTLE_EDGES(2),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk_i    (clk),
        .iRsn     (rst_n),
        .req_if   (bus),
        .count_o  (count),
        .div_clk_i(div_clk),
        .timeout_o(tmo)
    );

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          rr_m = 0;
    logic [15:0] req_cnt [4];
    int          n_ack = 0;
    int          n_tmo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External divider model: toggles when its counter reaches count
    logic        div_run = 1'b1;
    logic [15:0] dcnt = 16'd0;
    initial div_clk = 1'b0;
    always @(posedge clk) begin
        if (div_run) begin
            if (dcnt >= count) begin
                dcnt    <= 16'd0;
                div_clk <= ~div_clk;
            end else begin
                dcnt <= dcnt + 16'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one requester (caller sits at a negedge)
    task automatic drive_req(input int id, input logic [15:0] c);
        req_cnt[id] = c;
        bus.cnt_req[16*id +: 16] = c;
        bus.req[id] = 1'b1;
    endtask

    // Push expected services in round-robin order for a batch of requests
    task automatic predict(input logic [3:0] mask);
        int last;
        last = rr_m;
        for (int i = 0; i < 4; i++) begin
            int k;
            exp_t e;
            k = (rr_m + i) % 4;
            if (mask[k]) begin
                e.id  = k;
                e.cnt = (req_cnt[k] == 16'd0) ? 1 : int'(req_cnt[k]);
                sb.push_back(e);
                last = k;
            end
        end
        rr_m = (last + 1) % 4;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        check("wait_idle_done", 32'(done), 32'd1);
    endtask

    // Ack scoreboard monitor; also releases a requester after its ack
    logic [3:0] prev_ack = 4'd0;
    always @(negedge clk) begin
        if (rst_n && bus.ack != 4'd0) begin
            n_ack++;
            check("ack_single_cycle", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(bus.ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_vec", 32'(bus.ack), 32'(4'b0001 << e.id));
                check("ack_grant_id", 32'(bus.grant_id), 32'(e.id));
                check("ack_count", 32'(count), 32'(e.cnt));
            end
            bus.req = bus.req & ~bus.ack;
        end
        if (rst_n && tmo) n_tmo++;
        prev_ack = bus.ack;
    end

    // Apply-timing and half-period monitor
    logic        d1 = 1'b0, d2 = 1'b0, rst_prev = 1'b0, valid = 1'b0;
    logic [15:0] c1 = 16'd1;
    int          cyc = 0;
    always @(negedge clk) begin
        bit tog;
        tog = (div_clk != d1);
        cyc++;
        if (rst_n && rst_prev && count != c1) begin
            check("apply_after_toggle", 32'((d1 != d2) || tmo), 32'd1);
        end
        if (!rst_n || !div_run) begin
            valid = 1'b0;
        end else if (tog) begin
            if (valid) check("div_half_period", 32'(cyc), 32'(c1) + 32'd1);
            valid = 1'b1;
        end
        if (tog) cyc = 0;
        d2 = d1;
        d1 = div_clk;
        c1 = count;
        rst_prev = rst_n;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   snap;
        int   waited;
        bit   seen;
        rst_n       = 1'b0;
        bus.req     = 4'd0;
        bus.cnt_req = '0;
        for (int i = 0; i < 4; i++) req_cnt[i] = 16'd0;

        // Reset with divider running at count 1
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_ack", 32'(bus.ack), 32'd0);

        // Requester 2 asks for 9
        drive_req(2, 16'd9);
        predict(4'b0100);
        @(negedge clk);
        check("grant_id_r2", 32'(bus.grant_id), 32'd2);
        check("busy_after_grant", 32'(bus.busy), 32'd1);
        wait_idle(2000);
        check("count_9", 32'(count), 32'd9);
        repeat (25) @(negedge clk);

        // Requester 3 asks for the current count: ack 2 cycles later, no wait
        drive_req(3, 16'd9);
        predict(4'b1000);
        @(negedge clk);
        check("same_ack_early", 32'(bus.ack), 32'd0);
        @(negedge clk);
        check("same_ack", 32'(bus.ack), 32'b1000);
        check("same_count", 32'(count), 32'd9);
        wait_idle(100);

        // Simultaneous requests 0,1,3 from rr_ptr 0
        drive_req(0, 16'd3);
        drive_req(1, 16'd5);
        drive_req(3, 16'd7);
        predict(4'b1011);
        wait_idle(2000);
        check("rr_count_7", 32'(count), 32'd7);
        repeat (20) @(negedge clk);

        // Zero request is clamped to 1
        drive_req(2, 16'd0);
        predict(4'b0100);
        wait_idle(2000);
        check("zero_clamp", 32'(count), 32'd1);
        repeat (10) @(negedge clk);

        // Stalled divider forces a timeout apply
        div_run = 1'b0;
        repeat (4) @(negedge clk);
        drive_req(1, 16'd40);
        predict(4'b0010);
        seen = 1'b0;
        waited = 0;
        for (int n = 1; n <= 80000; n++) begin
            @(negedge clk);
            if (tmo) begin
                seen = 1'b1;
                waited = n;
                break;
            end
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_latency", 32'(waited), 32'(TimeoutCyc + 1));
        check("tmo_count", 32'(count), 32'd40);
        @(negedge clk);
        check("tmo_ack_next", 32'(bus.ack), 32'b0010);
        check("tmo_single", 32'(tmo), 32'd0);
        div_run = 1'b1;
        wait_idle(200);
        check("tmo_pulses", 32'(n_tmo), 32'd1);
        repeat (100) @(negedge clk);

        // Reset during SETTLE abandons the transaction
        drive_req(0, 16'd20);
        predict(4'b0001);
        seen = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (count == 16'd20) begin
                seen = 1'b1;
                break;
            end
        end
        check("settle_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        snap = n_ack;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_grant", 32'(bus.grant_id), 32'd0);
        check("mid_rst_tmo", 32'(tmo), 32'd0);
        bus.req = 4'd0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("no_ack_after_rst", 32'(n_ack - snap), 32'd0);
        check("idle_after_rst", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
